uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte port among N message sources, such as ping generators and debug streams.
- Grants are round-robin at message granularity: once a source is granted, it holds the transmitter until it hands over a byte flagged last.
- An optional idle gap is inserted between messages.
- A watchdog reclaims the grant from a source that stalls mid-message.
- Sits between the message-generator modules and the transmitter's _in/_in_valid/_in_ready port.

Parameters:
- N, 2, number of requesters (2..8).
- GAP_CLOCKS, 0, idle cycles forced after each completed or aborted message.
- TIMEOUT, 1000, consecutive cycles the granted source may hold _in_valid low mid-message before abort; 0 disables the watchdog.

Ports:
- _clock  input  1  system clock, all state on rising edge.
- _reset  input  1  asynchronous, active-low reset.
- _in_data  input  8*N  byte from requester i at bits [8i+7:8i].
- _in_valid  input  N  requester i has a byte.
- _in_last  input  N  byte from requester i ends its message; qualified by valid.
- _in_ready  output  N  byte from requester i is accepted this cycle.
- _out  output  8  byte to transmitter.
- _out_valid  output  1  _out is valid.
- _out_ready  input  1  transmitter accepts the byte.
- _grant  output  GW  index of the current owner, where GW = max(1,$clog2(N)).
- _busy  output  1  state is not IDLE.
- _abort  output  1  one-cycle pulse when the watchdog drops a grant.

Behaviour:
- Reset (_reset low, asynchronous):
  - state=IDLE, grant=0, rr_ptr=0, gap_cnt=0, wd_cnt=0.
  - All outputs are 0: _in_ready, _out, _out_valid, _busy, _abort.
- Outputs are a combinational function of the registered state and current inputs. A byte transfers on a cycle where _out_valid && _out_ready are both high.
- IDLE:
  - _out_valid=0 and _in_ready=0.
  - If any _in_valid is high, select the first valid index scanning rr_ptr, rr_ptr+1, ... mod N.
  - Next cycle: grant=selected, state=SEND, wd_cnt=0.
  - Arbitration therefore costs exactly 1 cycle; no byte passes in IDLE.
- SEND:
  - _out=_in_data[grant], _out_valid=_in_valid[grant], _in_ready[grant]=_out_ready. All other _in_ready=0 and all other inputs are ignored.
  - Transfer with _in_last[grant]=1: rr_ptr=(grant+1) mod N.
    - If GAP_CLOCKS>0: state=GAP, gap_cnt=GAP_CLOCKS-1.
    - Else: state=IDLE.
  - Transfer without last: remain in SEND, wd_cnt=0.
  - While _in_valid[grant]=0: wd_cnt increments and saturates.
  - Watchdog abort: if TIMEOUT>0 and wd_cnt==TIMEOUT-1 while _in_valid[grant]=0:
    - _abort=1 for that cycle.
    - rr_ptr=(grant+1) mod N, then the same GAP/IDLE transition as above.
    - No byte is transferred on the abort cycle.
  - _in_valid[grant]=1 with _out_ready=0 is backpressure, not a stall: wd_cnt resets to 0.
- GAP:
  - _out_valid=0 and _in_ready=0.
  - gap_cnt decrements each cycle; when it reaches 0, next state=IDLE.
  - Exactly GAP_CLOCKS cycles are spent in GAP.
- _busy=1 in SEND and GAP. _grant always reflects the grant register.
- Boundary cases:
  - A single-byte message (valid and last on the first byte) completes in one transfer.
  - Simultaneous requests are resolved by rr_ptr only; this guarantees no starvation under full load.
  - rr_ptr wraps N-1 to 0.
  - A requester dropping valid without last is legal; only the watchdog ends the grant.
  - _reset asserted mid-message abandons the message immediately; the transmitter sees _out_valid fall asynchronously.
- Widths:
  - gap_cnt and wd_cnt are 16 bits.
  - GAP_CLOCKS and TIMEOUT are restricted to <= 65535 (elaboration-time check).

Decomposition:
- A shared package uart_pkg holds:
  - typedef arb_state_e {IDLE, SEND, GAP}, 2 bits.
  - function rr_pick(valid, ptr) returning the index.
  - constant BYTE_W=8.
- One natural sub-module, rr_picker: combinational N-way round-robin selector. It takes valid[N] and ptr and outputs index plus any_valid. It is reusable by the future receive-side demux.
- The watchdog and gap counters stay inline.

Test Plan:
- N=2, GAP=0, source0 sends "PING\n" (5 bytes, last on 0x0A), source1 idle, _out_ready held 1 → 1 arbitration cycle, then 5 consecutive transfers, _grant=0, then IDLE.
- Both sources continuously valid with 3-byte messages → grant order 0,1,0,1; no byte from the non-granted source ever appears on _out.
- GAP_CLOCKS=4, back-to-back messages from source0 → exactly 4 cycles of _out_valid=0 in GAP plus 1 IDLE cycle between the last byte and the next message's first byte.
- TIMEOUT=10, source1 granted, sends 2 bytes then drops valid → _abort pulses on the 10th stalled cycle; source0, pending, is granted next.
- Backpressure: _out_ready low for 50 cycles with source valid, TIMEOUT=10 → no abort; the byte is held stable and accepted when ready rises.
- _reset pulsed low mid-message → outputs go 0 asynchronously; after release, source0 is served first (rr_ptr=0).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter and its
// receive-side counterparts.
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int MAX_N  = 8;
  localparam int PTR_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // First set bit of valid at or after ptr, wrapping modulo n.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_N-1:0] valid,
                                               input logic [PTR_W-1:0] ptr,
                                               input int n);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!found && k < n && valid[idx[PTR_W-1:0]]) begin
        rr_pick = idx[PTR_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the single transmitter byte port.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int N = 2
);
  logic [N-1:0][BYTE_W-1:0] _in_data;
  logic [N-1:0]             _in_valid;
  logic [N-1:0]             _in_last;
  logic [N-1:0]             _in_ready;
  logic [BYTE_W-1:0]        _out;
  logic                     _out_valid;
  logic                     _out_ready;

  modport slave (
    input  _in_data, _in_valid, _in_last, _out_ready,
    output _in_ready, _out, _out_valid
  );

  modport master (
    output _in_data, _in_valid, _in_last, _out_ready,
    input  _in_ready, _out, _out_valid
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational N-way round-robin selector: first valid index starting at ptr.
module rr_picker import uart_pkg::*; #(
  parameter  int N  = 2,
  localparam int GW = (N > 2) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          any_valid
);
  logic [PTR_W-1:0] pick;

  assign pick      = rr_pick(MAX_N'(valid), PTR_W'(ptr), N);
  assign idx       = GW'(pick);
  assign any_valid = |valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of one UART transmitter,
// with an optional inter-message gap and a mid-message stall watchdog.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter  int N          = 2,
  parameter  int GAP_CLOCKS = 0,
  parameter  int TIMEOUT    = 1000,
  localparam int GW         = (N > 2) ? $clog2(N) : 1
) (
  input  logic             _clock,
  input  logic             _reset,
  uart_tx_arbiter_if.slave bus,
  output logic [GW-1:0]    _grant,
  output logic             _busy,
  output logic             _abort
);
  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("uart_tx_arbiter: N must be 2..8");
  end
  if (GAP_CLOCKS < 0 || GAP_CLOCKS > 65535 || TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_cnt
    $error("uart_tx_arbiter: GAP_CLOCKS and TIMEOUT must fit in 16 bits");
  end

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CLOCKS - 1);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

  arb_state_e    state;
  logic [GW-1:0] grant, rr_ptr, pick, next_ptr;
  logic [15:0]   gap_cnt, wd_cnt;
  logic          any_valid, sel_valid, sel_last, xfer, wd_fire;

  rr_picker #(.N(N)) u_pick (
    .valid    (bus._in_valid),
    .ptr      (rr_ptr),
    .idx      (pick),
    .any_valid(any_valid)
  );

  assign sel_valid = bus._in_valid[grant];
  assign sel_last  = bus._in_last[grant];
  assign xfer      = (state == SEND) && sel_valid && bus._out_ready;
  assign wd_fire   = (TIMEOUT > 0) && (state == SEND) && !sel_valid && (wd_cnt == WD_LAST);
  assign next_ptr  = (grant == GW'(N - 1)) ? '0 : grant + 1'b1;

  // Outputs track live inputs so the transmitter sees the owner's byte with no added latency.
  always_comb begin
    bus._out       = '0;
    bus._out_valid = 1'b0;
    bus._in_ready  = '0;
    if (state == SEND) begin
      bus._out             = bus._in_data[grant];
      bus._out_valid       = sel_valid;
      bus._in_ready[grant] = bus._out_ready;
    end
  end

  assign _grant = grant;
  assign _busy  = (state != IDLE);
  assign _abort = wd_fire;

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          grant  <= pick;
          state  <= SEND;
          wd_cnt <= '0;
        end
        SEND: begin
          // A completed message and a watchdog abort release the grant identically.
          if ((xfer && sel_last) || wd_fire) begin
            rr_ptr <= next_ptr;
            wd_cnt <= '0;
            if (GAP_CLOCKS > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end else if (!sel_valid) begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 16'd1;
          end else begin
            wd_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
